ysyx_24100005_mem_arbiter: RTL and testbench

- Shares the single NPC memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between IFU/LSU and the memory model. Memory is reached through the DPI read/write functions in the top-level wrapper.
- One transaction outstanding at a time.
- Round-robin grant on ties; per-transaction response timeout with a sticky error flag.

---
 rtl/ysyx_24100005_mem_arbiter_if.sv | 50 +++++
 rtl/ysyx_24100005_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// rtl/ysyx_24100005_mem_arbiter_if.sv - IFU/LSU request, memory port and status bundle for the memory arbiter
interface ysyx_24100005_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        timeout_err;

  // Arbiter view.
  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output timeout_err
  );

  // Environment view: requesters plus memory model.
  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  timeout_err
  );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// rtl/ysyx_24100005_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single memory port with response timeout
module ysyx_24100005_mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_24100005_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  owner_t           owner;
  owner_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic             req_valid_q;
  logic [31:0]      addr_q;
  logic             wen_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;

  logic             ifu_resp_q;
  logic             lsu_resp_q;
  logic [31:0]      ifu_rdata_q;
  logic [31:0]      lsu_rdata_q;
  logic             err_q;

  logic             grant_ifu;
  logic             grant_lsu;
  logic             resp_done;
  logic [31:0]      resp_data;

  always_comb begin
    grant_ifu = bus.ifu_req_valid;
    grant_lsu = bus.lsu_req_valid;
    if (bus.ifu_req_valid && bus.lsu_req_valid) begin
      grant_ifu = (last_grant == OWN_LSU);
      grant_lsu = (last_grant == OWN_IFU);
    end
  end

  assign bus.ifu_req_ready = (state == IDLE) && grant_ifu;
  assign bus.lsu_req_ready = (state == IDLE) && grant_lsu;

  assign cnt_inc = cnt + 1'b1;

  // A response on the limit cycle wins over the timeout.
  always_comb begin
    resp_done = 1'b0;
    resp_data = ERR_DATA;
    if (state == WAIT) begin
      if (bus.mem_resp_valid) begin
        resp_done = 1'b1;
        resp_data = wen_q ? 32'h0 : bus.mem_rdata;
      end else if (cnt_inc == LIMIT) begin
        resp_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IFU;
      last_grant  <= OWN_LSU;
      cnt         <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ifu_req_ready) begin
            owner       <= OWN_IFU;
            last_grant  <= OWN_IFU;
            addr_q      <= bus.ifu_addr;
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end else if (bus.lsu_req_ready) begin
            owner       <= OWN_LSU;
            last_grant  <= OWN_LSU;
            addr_q      <= bus.lsu_addr;
            wen_q       <= bus.lsu_wen;
            wdata_q     <= bus.lsu_wdata;
            wmask_q     <= bus.lsu_wmask;
            req_valid_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            cnt         <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (resp_done) begin
            if (owner == OWN_IFU) begin
              ifu_resp_q  <= 1'b1;
              ifu_rdata_q <= resp_data;
            end else begin
              lsu_resp_q  <= 1'b1;
              lsu_rdata_q <= resp_data;
            end
            if (!bus.mem_resp_valid) begin
              err_q <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb/tb_ysyx_24100005_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter
module tb_ysyx_24100005_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter_if bus();

  ysyx_24100005_mem_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  req_t        ifu_cmd[$];
  req_t        lsu_cmd[$];
  req_t        exp_mem[$];
  logic [31:0] exp_ifu[$];
  logic [31:0] exp_lsu[$];
  logic        exp_grant[$];

  int          checks = 0;
  int          failures = 0;
  int          ready_dly = 0;
  int          resp_dly = 0;
  int          m_rd;
  int          m_sd;
  logic [31:0] m_addr;
  bit          mem_busy = 0;
  bit          ifu_fire = 0;
  bit          lsu_fire = 0;
  bit          prev_mv = 0;
  req_t        acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // IFU requester
  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (ifu_fire) begin
        ifu_fire = 0;
        void'(ifu_cmd.pop_front());
      end
      if (ifu_cmd.size() > 0) begin
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = ifu_cmd[0].addr;
      end else begin
        bus.ifu_req_valid = 1'b0;
      end
    end
  end

  // LSU requester
  initial begin
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (lsu_fire) begin
        lsu_fire = 0;
        void'(lsu_cmd.pop_front());
      end
      if (lsu_cmd.size() > 0) begin
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = lsu_cmd[0].addr;
        bus.lsu_wen       = lsu_cmd[0].wen;
        bus.lsu_wdata     = lsu_cmd[0].wdata;
        bus.lsu_wmask     = lsu_cmd[0].wmask;
      end else begin
        bus.lsu_req_valid = 1'b0;
      end
    end
  end

  // Memory model: read data = {addr[15:0], 16'h0413}
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid && !rst) begin
        mem_busy = 1;
        m_rd = ready_dly;
        m_sd = resp_dly;
        repeat (m_rd) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        m_addr = bus.mem_addr;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        if (m_sd >= 0) begin
          repeat (m_sd) @(negedge clk);
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = {m_addr[15:0], 16'h0413};
          @(negedge clk);
          bus.mem_resp_valid = 1'b0;
          bus.mem_rdata      = 32'h0;
        end
        mem_busy = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mv = 0;
      end else begin
        if (bus.ifu_req_valid && bus.lsu_req_valid)
          check("ready_exclusive", {63'h0, bus.ifu_req_ready & bus.lsu_req_ready}, 64'h0);
        if (bus.ifu_req_valid && bus.ifu_req_ready) begin
          if (exp_grant.size() == 0) fail_now("grant_unexpected_ifu", 64'h0, 64'h1);
          else check("grant_order", 64'h0, {63'h0, exp_grant.pop_front()});
          acc = '{ifu_cmd[0].addr, 1'b0, 32'h0, 4'h0};
          exp_mem.push_back(acc);
          ifu_fire = 1;
        end
        if (bus.lsu_req_valid && bus.lsu_req_ready) begin
          if (exp_grant.size() == 0) fail_now("grant_unexpected_lsu", 64'h1, 64'h0);
          else check("grant_order", 64'h1, {63'h0, exp_grant.pop_front()});
          exp_mem.push_back(lsu_cmd[0]);
          lsu_fire = 1;
        end
        if (bus.mem_req_valid) begin
          if (exp_mem.size() == 0) begin
            fail_now("mem_req_unexpected", {32'h0, bus.mem_addr}, 64'h0);
          end else begin
            check("mem_addr", {32'h0, bus.mem_addr}, {32'h0, exp_mem[0].addr});
            check("mem_wen_wmask_wdata", {27'h0, bus.mem_wen, bus.mem_wmask, bus.mem_wdata},
                  {27'h0, exp_mem[0].wen, exp_mem[0].wmask, exp_mem[0].wdata});
          end
        end
        if (prev_mv && !bus.mem_req_valid && exp_mem.size() > 0) void'(exp_mem.pop_front());
        prev_mv = bus.mem_req_valid;
        if (bus.ifu_resp_valid) begin
          if (exp_ifu.size() == 0) fail_now("ifu_resp_unexpected", {32'h0, bus.ifu_rdata}, 64'h0);
          else check("ifu_rdata", {32'h0, bus.ifu_rdata}, {32'h0, exp_ifu.pop_front()});
        end
        if (bus.lsu_resp_valid) begin
          if (exp_lsu.size() == 0) fail_now("lsu_resp_unexpected", {32'h0, bus.lsu_rdata}, 64'h0);
          else check("lsu_rdata", {32'h0, bus.lsu_rdata}, {32'h0, exp_lsu.pop_front()});
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_ifu.size() + exp_lsu.size() + exp_grant.size() + exp_mem.size()
            + ifu_cmd.size() + lsu_cmd.size() + int'(mem_busy)) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300)
      fail_now(name, 64'(exp_ifu.size() + exp_lsu.size() + exp_grant.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req_valid"}, {63'h0, bus.mem_req_valid}, 64'h0);
    check({tag, "_resp_valids"}, {62'h0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'h0);
    check({tag, "_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
    check({tag, "_mem_fields"}, {bus.mem_addr, bus.mem_wen, bus.mem_wmask, 27'h0}, 64'h0);
    check({tag, "_timeout_err"}, {63'h0, bus.timeout_err}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_readies", {62'h0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'h0);

    // Tie right after reset: I, L, I, L
    ifu_cmd.push_back('{32'h80000000, 1'b0, 32'h0, 4'h0});
    ifu_cmd.push_back('{32'h80000004, 1'b0, 32'h0, 4'h0});
    lsu_cmd.push_back('{32'h80000100, 1'b0, 32'h0, 4'h0});
    lsu_cmd.push_back('{32'h80000104, 1'b0, 32'h0, 4'h0});
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ifu = '{32'h00000413, 32'h00040413};
    exp_lsu = '{32'h01000413, 32'h01040413};
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done("tie_done");

    // IFU only
    ifu_cmd.push_back('{32'h80000000, 1'b0, 32'h0, 4'h0});
    exp_grant.push_back(1'b0);
    exp_ifu.push_back(32'h00000413);
    wait_done("ifu_only_done");

    // LSU write, memory ready delayed 3 cycles
    ready_dly = 3;
    lsu_cmd.push_back('{32'h80001000, 1'b1, 32'h12345678, 4'b0011});
    exp_grant.push_back(1'b1);
    exp_lsu.push_back(32'h0);
    wait_done("lsu_write_done");
    ready_dly = 0;

    // Back-to-back IFU: second accepted during first response pulse
    ifu_cmd.push_back('{32'h80000008, 1'b0, 32'h0, 4'h0});
    ifu_cmd.push_back('{32'h8000000C, 1'b0, 32'h0, 4'h0});
    exp_grant = '{1'b0, 1'b0};
    exp_ifu = '{32'h00080413, 32'h000C0413};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ifu_resp_valid && n < 50);
    if (n >= 50) fail_now("b2b_pulse_wait", 64'h0, 64'h1);
    else check("b2b_accept_in_pulse", {62'h0, bus.ifu_req_valid, bus.ifu_req_ready}, 64'h3);
    wait_done("b2b_done");

    // Response on the last allowed WAIT cycle is a normal response
    resp_dly = 3;
    ifu_cmd.push_back('{32'h80000010, 1'b0, 32'h0, 4'h0});
    exp_grant.push_back(1'b0);
    exp_ifu.push_back(32'h00100413);
    wait_done("limit_resp_done");
    check("limit_no_timeout_err", {63'h0, bus.timeout_err}, 64'h0);

    // Timeout with a late response
    resp_dly = 6;
    lsu_cmd.push_back('{32'h80000200, 1'b0, 32'h0, 4'h0});
    exp_grant.push_back(1'b1);
    exp_lsu.push_back(32'hDEADBEEF);
    wait_done("timeout_done");
    check("timeout_err_set", {63'h0, bus.timeout_err}, 64'h1);

    // Good transaction afterwards; error stays sticky
    resp_dly = 0;
    lsu_cmd.push_back('{32'h80000300, 1'b0, 32'h0, 4'h0});
    exp_grant.push_back(1'b1);
    exp_lsu.push_back(32'h03000413);
    wait_done("post_timeout_done");
    check("timeout_err_sticky", {63'h0, bus.timeout_err}, 64'h1);

    // Reset while in WAIT: in-flight transaction dropped
    resp_dly = 3;
    lsu_cmd.push_back('{32'h80000400, 1'b0, 32'h0, 4'h0});
    exp_grant.push_back(1'b1);
    n = 0;
    while (!(mem_busy && exp_mem.size() == 0 && exp_grant.size() == 0 && !bus.mem_req_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("reset_wait_entry", 64'h0, 64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    wait_done("midreset_done");
    check("midreset_timeout_err", {63'h0, bus.timeout_err}, 64'h0);
    resp_dly = 0;

    // Next tie goes to the IFU again
    ifu_cmd.push_back('{32'h80000020, 1'b0, 32'h0, 4'h0});
    lsu_cmd.push_back('{32'h80000500, 1'b0, 32'h0, 4'h0});
    exp_grant = '{1'b0, 1'b1};
    exp_ifu.push_back(32'h00200413);
    exp_lsu.push_back(32'h05000413);
    wait_done("tie_after_reset_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
